// File: rtl/comp_pkg.sv
// Shared definitions for the serial comparator controller: FSM encodings and
// the initial values of the running comparison flags.
package comp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic GT_INIT = 1'b0;
  localparam logic EQ_INIT = 1'b1;
  localparam logic LT_INIT = 1'b0;

endpackage

// File: rtl/comp_2.sv
// One 2-bit comparator digit: forwards a decided GT/LT from the more significant
// digits, otherwise compares its own digit pair unsigned.
module comp_2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       gt_i,
  input  logic       eq_i,
  input  logic       lt_i,
  output logic       gt_o,
  output logic       eq_o,
  output logic       lt_o
);

  always_comb begin
    gt_o = 1'b0;
    eq_o = 1'b0;
    lt_o = 1'b0;
    if (gt_i || lt_i) begin
      gt_o = gt_i;
      lt_o = lt_i;
    end else begin
      gt_o = (a > b);
      lt_o = (a < b);
      eq_o = eq_i && (a == b);
    end
  end

endmodule

// File: rtl/comp_seq_ctrl.sv
// Serial magnitude comparator: steps one comp_2 digit slice over two 2N-bit
// operands, MSB digit first, with start/busy/done handshake and signed mode.
module comp_seq_ctrl
  import comp_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = $clog2(N + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2*N-1:0]  x,
  input  logic [2*N-1:0]  y,
  input  logic            NEG,
  input  logic            early,
  output logic            busy,
  output logic            done,
  output logic            GTo,
  output logic            EQo,
  output logic            LTo,
  output logic [CW-1:0]   count
);

  localparam logic [CW-1:0] N_CNT = CW'(N);

  state_t          state_q, state_d;
  logic [2*N-1:0]  xs_q, xs_d;
  logic [2*N-1:0]  ys_q, ys_d;
  logic            gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;
  logic            gto_q, gto_d, eqo_q, eqo_d, lto_q, lto_d;
  logic [CW-1:0]   count_q, count_d;
  logic            flip_q, flip_d;
  logic            early_q, early_d;

  logic            s_gt, s_eq, s_lt;
  logic [CW-1:0]   count_inc;

  comp_2 u_slice (
    .a    (xs_q[2*N-1 -: 2]),
    .b    (ys_q[2*N-1 -: 2]),
    .gt_i (gt_q),
    .eq_i (eq_q),
    .lt_i (lt_q),
    .gt_o (s_gt),
    .eq_o (s_eq),
    .lt_o (s_lt)
  );

  assign count_inc = count_q + 1'b1;

  always_comb begin
    state_d = state_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    gto_d   = gto_q;
    eqo_d   = eqo_q;
    lto_d   = lto_q;
    count_d = count_q;
    flip_d  = flip_q;
    early_d = early_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          xs_d    = x;
          ys_d    = y;
          gt_d    = GT_INIT;
          eq_d    = EQ_INIT;
          lt_d    = LT_INIT;
          count_d = '0;
          // Differing sign bits invert the unsigned ordering.
          flip_d  = NEG & (x[2*N-1] ^ y[2*N-1]);
          early_d = early;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        gt_d    = s_gt;
        eq_d    = s_eq;
        lt_d    = s_lt;
        xs_d    = xs_q << 2;
        ys_d    = ys_q << 2;
        count_d = count_inc;
        if (count_inc == N_CNT || (early_q && !s_eq)) begin
          gto_d   = s_gt ^ flip_q;
          eqo_d   = s_eq;
          lto_d   = s_lt ^ flip_q;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      xs_q    <= '0;
      ys_q    <= '0;
      gt_q    <= GT_INIT;
      eq_q    <= EQ_INIT;
      lt_q    <= LT_INIT;
      gto_q   <= 1'b0;
      eqo_q   <= 1'b0;
      lto_q   <= 1'b0;
      count_q <= '0;
      flip_q  <= 1'b0;
      early_q <= 1'b0;
    end else begin
      state_q <= state_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      gto_q   <= gto_d;
      eqo_q   <= eqo_d;
      lto_q   <= lto_d;
      count_q <= count_d;
      flip_q  <= flip_d;
      early_q <= early_d;
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_DONE);
  assign GTo   = gto_q;
  assign EQo   = eqo_q;
  assign LTo   = lto_q;
  assign count = count_q;

endmodule

// File: tb/tb_comp_seq_ctrl.sv
// Directed bench for comp_seq_ctrl (N=4): vector table plus sequences for
// busy-time start, mid-run reset and back-to-back operation.
module tb_comp_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] x, y;
  logic       NEG, early;
  logic       busy, done, GTo, EQo, LTo;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  comp_seq_ctrl #(.N(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     (x),
    .y     (y),
    .NEG   (NEG),
    .early (early),
    .busy  (busy),
    .done  (done),
    .GTo   (GTo),
    .EQo   (EQo),
    .LTo   (LTo),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic       neg;
    logic       early;
    logic       gt;
    logic       eq;
    logic       lt;
    int         cnt;
    int         lat;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Returns the number of edges after the accepting edge until done is seen.
  task automatic run_op(input vec_t v, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    x = v.x; y = v.y; NEG = v.neg; early = v.early; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 99;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int pulses;
    int last_done;
    int prev_done;
    logic [2:0] cap_flags;
    int cap_cnt;

    vecs[0]  = '{8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4, 4};
    vecs[1]  = '{8'h80, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4, 4};
    vecs[2]  = '{8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4, 4};
    vecs[3]  = '{8'hC0, 8'h40, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1};
    vecs[4]  = '{8'hC0, 8'h40, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4, 4};
    vecs[5]  = '{8'h12, 8'h13, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4, 4};
    vecs[6]  = '{8'hFF, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1};
    vecs[7]  = '{8'hFE, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4, 4};
    vecs[8]  = '{8'h00, 8'h40, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1};
    vecs[9]  = '{8'h7F, 8'h80, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1};
    vecs[10] = '{8'h25, 8'h24, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4, 4};

    rst = 1'b1; start = 1'b0; x = '0; y = '0; NEG = 1'b0; early = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy",  busy,  0);
    chk("reset_done",  done,  0);
    chk("reset_gt",    GTo,   0);
    chk("reset_eq",    EQo,   0);
    chk("reset_lt",    LTo,   0);
    chk("reset_count", count, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i], lat);
      $display("vec %0d x=%02h y=%02h neg=%0b early=%0b -> lat=%0d gt=%0b eq=%0b lt=%0b count=%0d",
               i, vecs[i].x, vecs[i].y, vecs[i].neg, vecs[i].early, lat, GTo, EQo, LTo, count);
      chk($sformatf("vec%0d_latency", i), lat,   vecs[i].lat);
      chk($sformatf("vec%0d_gt", i),      GTo,   vecs[i].gt);
      chk($sformatf("vec%0d_eq", i),      EQo,   vecs[i].eq);
      chk($sformatf("vec%0d_lt", i),      LTo,   vecs[i].lt);
      chk($sformatf("vec%0d_count", i),   count, vecs[i].cnt);
      chk($sformatf("vec%0d_busy", i),    busy,  1);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_done_width", i), done, 0);
      chk($sformatf("vec%0d_hold_gt", i),    GTo,  vecs[i].gt);
    end

    // Start pulsed during RUN with other operands must be ignored.
    pulses = 0; cap_flags = '0; cap_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      start = (c == 0 || c == 2);
      x     = (c == 0) ? 8'h80 : 8'h00;
      y     = (c == 0) ? 8'h7F : 8'hFF;
      NEG   = (c != 0);
      early = (c != 0);
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        cap_flags = {GTo, EQo, LTo};
        cap_cnt   = count;
      end
    end
    start = 1'b0;
    $display("busy-start seq: pulses=%0d flags=%03b count=%0d", pulses, cap_flags, cap_cnt);
    chk("busy_start_pulses", pulses,    1);
    chk("busy_start_flags",  cap_flags, 3'b100);
    chk("busy_start_count",  cap_cnt,   4);

    // Reset on the second RUN cycle aborts without a done pulse.
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      start = (c == 0);
      x = 8'hA5; y = 8'h00; NEG = 1'b0; early = 1'b0;
      rst = (c == 2);
      @(posedge clk); #1;
      if (c == 2) begin
        chk("abort_busy",  busy,  0);
        chk("abort_gt",    GTo,   0);
        chk("abort_eq",    EQo,   0);
        chk("abort_lt",    LTo,   0);
        chk("abort_count", count, 0);
      end
      if (done) pulses++;
    end
    rst = 1'b0;
    $display("abort seq: done pulses after reset=%0d", pulses);
    chk("abort_no_done", pulses, 0);
    run_op(vecs[1], lat);
    $display("post-abort op: lat=%0d gt=%0b eq=%0b lt=%0b count=%0d", lat, GTo, EQo, LTo, count);
    chk("post_abort_latency", lat,   4);
    chk("post_abort_gt",      GTo,   1);
    chk("post_abort_count",   count, 4);

    // Start held high: one done every N+2 cycles, each one cycle wide.
    @(negedge clk);
    while (busy) @(negedge clk);
    pulses = 0; last_done = 0; prev_done = -10;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) @(negedge clk);
      start = (c < 20);
      x = 8'hA5; y = 8'hA5; NEG = 1'b0; early = 1'b0;
      @(posedge clk); #1;
      if (done) begin
        if (last_done == 1) chk("held_done_width", 2, 1);
        if (pulses > 0) chk($sformatf("held_interval%0d", pulses), c - prev_done, 6);
        prev_done = c;
        pulses++;
        last_done = 1;
        chk($sformatf("held_eq%0d", pulses), EQo, 1);
      end else begin
        last_done = 0;
      end
    end
    start = 1'b0;
    $display("held-start seq: done pulses=%0d", pulses);
    chk("held_pulses", pulses, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
